// File: rtl/win_acc_pkg.sv
// Shared types and defaults for the window accumulator.
// Imported by the top level and its output slot.
package win_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FULL
    } win_state_e;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_WINDOW = 8;
    localparam int unsigned DEF_CNT_W  = $clog2(DEF_WINDOW + 1);

    function automatic int unsigned cnt_width(input int unsigned window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/acc_out_slot.sv
// One-entry valid/ready holding register for a closed window result.
// A load always wins; the caller only loads when the slot is free or draining.
module acc_out_slot
    import win_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CW    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [CW-1:0]    cnt_i,
    input  logic             ovf_i,
    input  logic             drain_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] sum_o,
    output logic [CW-1:0]    cnt_o,
    output logic             ovf_o
);

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            sum_q   <= sum_i;
            cnt_q   <= cnt_i;
            ovf_q   <= ovf_i;
        end else if (drain_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign cnt_o   = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/window_accumulator.sv
// Sums a sample stream over fixed or flushed windows and hands
// (sum, count, overflow) to the divider through a one-entry slot.
module window_accumulator
    import win_acc_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned WINDOW = DEF_WINDOW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_count,
    output logic             out_overflow
);

    localparam int unsigned CW      = cnt_width(WINDOW);
    localparam logic [CW-1:0] WIN_CNT = CW'(WINDOW);

    win_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             slot_valid;
    logic             slot_free;
    logic             close;
    logic [WIDTH:0]   sum_ext;
    logic [CW-1:0]    cnt_inc;
    logic             ovf_inc;

    logic             load;
    logic [WIDTH-1:0] ld_sum;
    logic [CW-1:0]    ld_cnt;
    logic             ld_ovf;
    logic [CW-1:0]    slot_cnt;

    assign in_ready  = (state_q != FULL);
    assign accept    = in_valid & in_ready;
    assign slot_free = ~slot_valid | out_ready;

    assign sum_ext = {1'b0, acc_q} + (accept ? {1'b0, in_data} : '0);
    assign cnt_inc = cnt_q + CW'(accept);
    assign ovf_inc = ovf_q | sum_ext[WIDTH];

    // A flush only closes a window that holds at least one sample after this edge.
    assign close = in_ready
                 & ((accept & (cnt_inc == WIN_CNT))
                 | (flush & (cnt_inc != '0)));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        ld_sum  = sum_ext[WIDTH-1:0];
        ld_cnt  = cnt_inc;
        ld_ovf  = ovf_inc;
        unique case (state_q)
            FULL: begin
                ld_sum = acc_q;
                ld_cnt = cnt_q;
                ld_ovf = ovf_q;
                if (slot_free) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            IDLE, ACCUM: begin
                if (close && slot_free) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d   = sum_ext[WIDTH-1:0];
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_inc;
                    if (close) begin
                        state_d = FULL;
                    end else if (cnt_inc == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    acc_out_slot #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .sum_i   (ld_sum),
        .cnt_i   (ld_cnt),
        .ovf_i   (ld_ovf),
        .drain_i (out_ready),
        .valid_o (slot_valid),
        .sum_o   (out_sum),
        .cnt_o   (slot_cnt),
        .ovf_o   (out_overflow)
    );

    assign out_valid = slot_valid;
    assign out_count = WIDTH'(slot_cnt);

endmodule

// File: tb/tb_window_accumulator.sv
// Directed and random checks of window_accumulator against a
// queue-based window model.
module tb_window_accumulator;

    localparam int W   = 4;
    localparam int WID = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [WID-1:0] in_data;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [WID-1:0] out_sum;
    logic [WID-1:0] out_count;
    logic           out_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    window_accumulator #(
        .WIDTH  (WID),
        .WINDOW (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // Model: open window as a list of samples, one closed result
    // waiting for the slot, and the slot itself.
    int unsigned    win[$];
    bit             hv;
    longint unsigned htot;
    int             hcnt;
    bit             sv;
    longint unsigned stot;
    int             scnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        hv = 0;
        sv = 0;
        htot = 0;
        hcnt = 0;
        stot = 0;
        scnt = 0;
    endtask

    task automatic model_edge(input bit v, input int unsigned d,
                              input bit f, input bit r);
        bit loaded;
        longint unsigned tot;
        loaded = 0;
        if (hv) begin
            if (!sv || r) begin
                sv = 1; stot = htot; scnt = hcnt;
                hv = 0; loaded = 1;
            end
        end else begin
            if (v) win.push_back(d);
            if (win.size() == W || (f && win.size() > 0)) begin
                tot = 0;
                foreach (win[i]) tot += win[i];
                if (!sv || r) begin
                    sv = 1; stot = tot; scnt = win.size();
                    loaded = 1;
                end else begin
                    hv = 1; htot = tot; hcnt = win.size();
                end
                win.delete();
            end
        end
        if (!loaded && sv && r) sv = 0;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, !hv);
        chk("out_valid", out_valid, sv);
        if (sv) begin
            chk("out_sum", out_sum, stot[31:0]);
            chk("out_count", out_count, scnt);
            chk("out_overflow", out_overflow, stot > 64'hFFFF_FFFF);
        end
    endtask

    task automatic cyc(input bit v, input int unsigned d,
                       input bit f, input bit r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_edge(v, d, f, r);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        model_reset();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;
    endtask

    task automatic expect_res(input string tag, input int unsigned s,
                              input int unsigned c, input bit o);
        chk({tag, "_v"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, s);
        chk({tag, "_cnt"}, out_count, c);
        chk({tag, "_ovf"}, out_overflow, o);
    endtask

    initial begin
        model_reset();
        do_reset(2);

        // Basic window; next window starts with no bubble
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 1);
        expect_res("basic", 10, 4, 0);
        chk("basic_rdy5", in_ready, 1);
        for (int i = 5; i <= 8; i++) cyc(1, i, 0, 1);
        expect_res("basic2", 26, 4, 0);

        // Overflow, then clean window
        cyc(1, 32'hFFFF_FFFF, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        expect_res("ovf", 1, 4, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        expect_res("ovf_next", 4, 4, 0);
        cyc(0, 0, 0, 1);

        // Backpressure
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
        expect_res("bp1", 20, 4, 0);
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
        chk("bp_full_rdy", in_ready, 0);
        for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
        chk("bp_stall_rdy", in_ready, 0);
        expect_res("bp_hold", 20, 4, 0);
        cyc(1, 5, 0, 1);
        expect_res("bp2", 20, 4, 0);
        chk("bp_rdy_back", in_ready, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("bp_drained", out_valid, 0);

        // Flush alone, then flush with empty window
        cyc(1, 7, 0, 1);
        cyc(1, 9, 0, 1);
        cyc(0, 0, 1, 1);
        expect_res("flush", 16, 2, 0);
        cyc(0, 0, 1, 1);
        chk("flush_empty", out_valid, 0);

        // Flush together with a sample
        cyc(1, 1, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 3, 1, 1);
        expect_res("flush_smp", 6, 3, 0);
        cyc(0, 0, 0, 1);

        // Reset mid-window
        cyc(1, 9, 0, 1);
        cyc(1, 9, 0, 1);
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        expect_res("post_rst", 4, 4, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned d;
            if ($urandom_range(0, 3) == 0)
                d = 32'hF000_0000 | $urandom();
            else
                d = $urandom_range(0, 100);
            cyc($urandom_range(0, 3) != 0, d,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_accumulator.md
# window_accumulator

Front-end stage for the averaging datapath. It accepts a stream of unsigned samples over a valid/ready handshake and sums them over a window of `WINDOW` samples, or fewer if `flush` cuts the window short. It hands each completed (sum, count, overflow) triple to the downstream divider over a second valid/ready handshake, so the divider can form sum/count. A one-entry output slot lets the next window accumulate while the previous result waits for the divider.

## Interface
- `WIDTH`, 32, sample, sum and count width.
- `WINDOW`, 8, samples per full window; legal range 2..256.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle; combinational from the state register only.
- `in_data`  in  WIDTH  unsigned sample.
- `flush`  in  1  one-cycle pulse that closes the current partial window.
- `out_valid`  out  1  output slot holds a result.
- `out_ready`  in  1  downstream takes the result.
- `out_sum`  out  WIDTH  window sum, modulo 2^WIDTH.
- `out_count`  out  WIDTH  samples in the window, 1..WINDOW; never 0.
- `out_overflow`  out  1  the true sum exceeded 2^WIDTH−1.

## Operation
- **States:** IDLE (count=0), ACCUM (0<count<WINDOW), FULL (window closed, output slot occupied).
- **Ready:** `in_ready` = 1 in IDLE and ACCUM, 0 in FULL.
- **Accept:** a sample is accepted when `in_valid & in_ready`.
  - acc ← acc + in_data, computed at WIDTH+1 bits.
  - count ← count + 1.
  - sticky ovf ← ovf | carry.
- **Window close:** the window closes on the same edge as the accept that makes count = WINDOW.
- **Flush close:** the window also closes on `flush` when the post-edge count > 0. A sample accepted in the same cycle is included.
  - `flush` with count = 0 and no accept is ignored.
  - `flush` in FULL is ignored.
- **On close:** if the slot is free, or is being drained this cycle (`out_valid & out_ready`):
  - load acc, count and ovf into the slot;
  - clear the accumulator;
  - go to IDLE.
- **Otherwise:** go to FULL and hold acc. On the first edge where the slot frees, load the slot, clear the accumulator and go to IDLE.
- **Arithmetic:** `out_sum` keeps the low WIDTH bits of the sum. `out_overflow` is the OR of all carries in that window.
- **Output stability:** `out_*` stay stable while `out_valid & !out_ready`.

## Timing
- **Reset:** while `rst_n`=0 at an edge:
  - state → IDLE; acc, count and ovf → 0;
  - `out_valid`, `out_sum`, `out_count`, `out_overflow` → 0;
  - any in-progress window is discarded;
  - samples presented during reset are not accepted, even though `in_ready` reads 1.
- **Latency:** a closing accept or `flush` at edge k raises `out_valid` after edge k, when the slot is free.
- **Throughput:** 1 sample/cycle sustained when `out_ready` is held high. There are no bubbles between windows.
- **Drain:** `out_valid` falls after the handshake edge, unless a new window is loaded on that same edge, in which case it stays high with new data.
- **Stall in FULL:** `in_ready` returns to 1 in the cycle after the slot frees.

## Structure
- **Package `win_acc_pkg`:**
  - state enum typedef (IDLE, ACCUM, FULL);
  - default `WIDTH` and `WINDOW` localparams;
  - count width constant $clog2(WINDOW+1).
- **Sub-module `acc_out_slot`:** one-entry valid/ready register holding {sum, count, overflow}, with load and drain ports. The FSM and accumulator stay in the top level.

## Test plan
1. **Basic window:** WINDOW=4, `out_ready`=1; samples 1,2,3,4 on consecutive cycles.
   - `out_valid` 1 cycle after the 4th accept; sum=10, count=4, ovf=0.
   - 5th sample is accepted in that same cycle.
2. **Overflow:** WINDOW=4; samples 0xFFFF_FFFF, 2, 0, 0.
   - sum=0x0000_0001, count=4, ovf=1.
   - The next window reports ovf=0.
3. **Backpressure:** WINDOW=4, `out_ready`=0; twelve samples of 5.
   - 1st result: sum=20, count=4, held stable.
   - 2nd window closes: state FULL, `in_ready`=0, the 9th sample is stalled.
   - Pulse `out_ready`: 1st result drains, and the 2nd result (sum=20) appears in the next cycle.
   - `in_ready`=1 one cycle after the slot frees.
4. **Flush:**
   - Samples 7, 9, then `flush` alone → sum=16, count=2.
   - A second `flush` with count=0 produces no output.
5. **Flush with sample:** `flush` asserted with the accept of sample 3 (after 1, 2) → sum=6, count=3.
6. **Reset mid-window:** accept 2 samples, then drive `rst_n` low for 1 cycle.
   - All outputs are 0.
   - The following 4 samples of 1 give sum=4, count=4.
